// File: rtl/puf_challenge_ctrl_if.sv
// Host and oscillator-bank signals of the PUF challenge controller; master is the controller side.
// Host side: ena/start/seed in, busy/done/response/tie out. Bank side: challenge/cnt_clr/cnt_en out, counts in.
interface puf_challenge_ctrl_if #(
  parameter int N_BITS = 8
);
  logic              ena;
  logic              start;
  logic [3:0]        seed;
  logic [15:0]       count_a;
  logic [15:0]       count_b;
  logic [3:0]        challenge;
  logic              cnt_clr;
  logic              cnt_en;
  logic              busy;
  logic              done;
  logic [N_BITS-1:0] response;
  logic              tie;

  modport master (
    input  ena, start, seed, count_a, count_b,
    output challenge, cnt_clr, cnt_en, busy, done, response, tie
  );

  modport slave (
    output ena, start, seed, count_a, count_b,
    input  challenge, cnt_clr, cnt_en, busy, done, response, tie
  );
endinterface

// File: rtl/puf_challenge_ctrl.sv
// RO-PUF challenge sequencer: N_BITS x (clear, count window, settle, compare), done N_BITS*P+1 cycles after start.
// No backpressure; ena low aborts. PUF_MAJORITY_EN: each challenge measured 3 times, majority vote per bit.
module puf_challenge_ctrl #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 4,
  parameter int N_BITS        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  puf_challenge_ctrl_if.master bus
);

  localparam int TMAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, COUNT, SETTLE, COMPARE, DONE} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     tmr;
  logic [IW-1:0]     bit_idx;
  logic [3:0]        challenge_q;
  logic              cnt_clr_q, cnt_en_q, busy_q, done_q, tie_q;
  logic [N_BITS-1:0] response_q;

  logic accept, abort, tmr_last, bit_last, meas_last, bit_val;
  logic cmp_gt, cmp_eq;

  assign cmp_gt = bus.count_a > bus.count_b;
  assign cmp_eq = bus.count_a == bus.count_b;

`ifdef PUF_MAJORITY_EN
  logic [1:0] meas, votes;

  // votes holds the greater-than results of the earlier measurements of this challenge
  assign meas_last = (meas == 2'd2);
  assign bit_val   = ((votes + {1'b0, cmp_gt}) >= 2'd2);

  always_ff @(posedge clk) begin
    if (!rst_n || state == IDLE) begin
      meas  <= '0;
      votes <= '0;
    end else if (state == COMPARE) begin
      if (meas_last) begin
        meas  <= '0;
        votes <= '0;
      end else begin
        meas  <= meas + 2'd1;
        votes <= votes + {1'b0, cmp_gt};
      end
    end
  end
`else
  assign meas_last = 1'b1;
  assign bit_val   = cmp_gt;
`endif

  always_comb begin
    accept    = bus.start && bus.ena;
    abort     = (state != IDLE) && !bus.ena;
    bit_last  = (bit_idx == IW'(N_BITS - 1));
    tmr_last  = 1'b0;
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CLEAR;
      CLEAR:   state_nxt = COUNT;
      COUNT: begin
        tmr_last = (tmr == TW'(WINDOW_CYCLES - 1));
        if (tmr_last) state_nxt = SETTLE;
      end
      SETTLE: begin
        tmr_last = (tmr == TW'(SETTLE_CYCLES - 1));
        if (tmr_last) state_nxt = COMPARE;
      end
      COMPARE: state_nxt = (meas_last && bit_last) ? DONE : CLEAR;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr         <= '0;
      bit_idx     <= '0;
      challenge_q <= '0;
      cnt_clr_q   <= 1'b0;
      cnt_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      response_q  <= '0;
      tie_q       <= 1'b0;
    end else begin
      cnt_clr_q <= (state_nxt == CLEAR);
      cnt_en_q  <= (state_nxt == COUNT);
      busy_q    <= (state_nxt != IDLE);
      done_q    <= (state_nxt == DONE);

      if ((state_nxt != state) || !((state == COUNT) || (state == SETTLE))) tmr <= '0;
      else                                                                  tmr <= tmr + 1'b1;

      if (abort) begin
        response_q <= '0;
        tie_q      <= 1'b0;
      end else if (state == IDLE) begin
        if (accept) begin
          challenge_q <= bus.seed;
          bit_idx     <= '0;
          response_q  <= '0;
          tie_q       <= 1'b0;
        end
      end else if (state == COMPARE) begin
        if (cmp_eq) tie_q <= 1'b1;
        if (meas_last) begin
          response_q[bit_idx] <= bit_val;
          if (!bit_last) begin
            bit_idx     <= bit_idx + 1'b1;
            challenge_q <= challenge_q + 4'd1;
          end
        end
      end
    end
  end

  assign bus.challenge = challenge_q;
  assign bus.cnt_clr   = cnt_clr_q;
  assign bus.cnt_en    = cnt_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.response  = response_q;
  assign bus.tie       = tie_q;

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// Scoreboard bench: stimulus pushes expected challenges/results, monitor pops on cnt_clr/done.
// Behavioural oscillator banks accumulate per-measurement rates and present counts only once settled.
module tb_puf_challenge_ctrl;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int N  = 4;
  localparam int P  = W + S + 2;
`ifdef PUF_MAJORITY_EN
  localparam int M  = 3;
`else
  localparam int M  = 1;
`endif
  localparam int NM = N * M;

  typedef struct packed {
    logic [N-1:0] resp;
    logic         tie;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;

  puf_challenge_ctrl_if #(.N_BITS(N)) bus ();

  puf_challenge_ctrl #(
    .WINDOW_CYCLES(W),
    .SETTLE_CYCLES(S),
    .N_BITS       (N)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          ra[NM];
  int          rb[NM];
  logic [3:0]  exp_chal_q[$];
  res_t        exp_res_q[$];
  res_t        last_res;
  int          kb = 0;
  int          run_cyc = 0;
  int          en_run = 0;
  int          done_cnt = 0;
  logic [3:0]  win_chal = '0;
  bit          chal_moved = 1'b0;
  bit          mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Oscillator banks: counts are garbage while counting and until SETTLE quiet cycles have passed.
  initial begin : bank
    int        low;
    bit        valid;
    logic [15:0] acc_a, acc_b;
    low = 0; acc_a = '0; acc_b = '0;
    bus.count_a = '0;
    bus.count_b = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.start && bus.ena && bus.busy === 1'b0) kb = -1;
      valid = (bus.cnt_en !== 1'b1) && (low >= S);
      if (bus.cnt_clr === 1'b1) begin
        kb++;
        acc_a = '0;
        acc_b = '0;
      end
      if (bus.cnt_en === 1'b1) begin
        if (kb >= 0 && kb < NM) begin
          acc_a = acc_a + 16'(ra[kb]);
          acc_b = acc_b + 16'(rb[kb]);
        end
        low = 0;
      end else if (low < 1000) begin
        low++;
      end
      bus.count_a = valid ? acc_a : 16'($urandom);
      bus.count_b = valid ? acc_b : 16'($urandom);
    end
  end

  initial begin : monitor
    res_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (rst_n && bus.start && bus.ena && bus.busy === 1'b0) run_cyc = 0;
        else run_cyc++;
        if (bus.cnt_clr === 1'b1) begin
          if (exp_chal_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_clear: got cnt_clr=1 expected no measurement");
          end else begin
            chk("challenge", 32'(bus.challenge), 32'(exp_chal_q.pop_front()));
          end
          win_chal   = bus.challenge;
          chal_moved = 1'b0;
        end
        if (bus.cnt_en === 1'b1) begin
          en_run++;
          if (bus.challenge !== win_chal) chal_moved = 1'b1;
        end else if (en_run > 0) begin
          if (bus.busy === 1'b1) begin
            chk("window_len", 32'(en_run), 32'(W));
            chk("chal_stable", 32'(chal_moved), 32'd0);
          end
          en_run = 0;
        end
        if (bus.done === 1'b1) begin
          done_cnt++;
          if (exp_res_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done=1 expected none");
          end else begin
            e = exp_res_q.pop_front();
            chk("response", 32'(bus.response), 32'(e.resp));
            chk("tie", 32'(bus.tie), 32'(e.tie));
            chk("done_cycle", 32'(run_cyc), 32'(NM * P + 1));
          end
        end
      end
    end
  end

  // rel: 0 = A<B, 1 = A>B, 2 = equal
  task automatic set_rel(input int k, input int rel);
    int a, b;
    case (rel)
      1: begin b = $urandom_range(3999, 1); a = $urandom_range(4000, b + 1); end
      0: begin a = $urandom_range(3999, 1); b = $urandom_range(4000, a + 1); end
      default: begin a = $urandom_range(4000, 1); b = a; end
    endcase
    ra[k] = a;
    rb[k] = b;
  endtask

  task automatic fill_bit(input int i, input int rel);
    for (int m = 0; m < M; m++) set_rel(i * M + m, rel);
  endtask

  task automatic fill_random(input bit allow_eq);
    for (int k = 0; k < NM; k++)
      set_rel(k, (allow_eq && $urandom_range(7, 0) == 0) ? 2 : int'($urandom_range(1, 0)));
  endtask

  // Reference: challenge k/M steps from the seed mod 16; each bit is the majority of its measurements.
  function automatic res_t model();
    res_t r;
    int   votes;
    r = '0;
    for (int i = 0; i < N; i++) begin
      votes = 0;
      for (int m = 0; m < M; m++) begin
        if (ra[i * M + m] > rb[i * M + m]) votes++;
        if (ra[i * M + m] == rb[i * M + m]) r.tie = 1'b1;
      end
      r.resp[i] = (2 * votes > M);
    end
    return r;
  endfunction

  task automatic do_run(input logic [3:0] sd, input bit abort, input bit poke);
    int n;
    int dc;
    int nmeas;
    nmeas = abort ? 2 : NM;
    for (int k = 0; k < nmeas; k++) exp_chal_q.push_back(4'((int'(sd) + k / M) % 16));
    if (!abort) begin
      last_res = model();
      exp_res_q.push_back(last_res);
    end
    bus.seed  = sd;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.seed  = 4'($urandom);
    if (abort) begin
      n = 0;
      while (!(kb == 1 && bus.cnt_en === 1'b1) && n < 500) begin tick(); n++; end
      if (n >= 500) begin
        checks++; errors++;
        $display("FAIL abort_wait: got no second window expected one within 500 cycles");
      end
      repeat (3) tick();
      chk("tie_pre_abort", 32'(bus.tie), 32'd1);
      dc = done_cnt;
      bus.ena = 1'b0;
      tick();
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_cnt_en", 32'(bus.cnt_en), 32'd0);
      chk("abort_response", 32'(bus.response), 32'd0);
      chk("abort_tie", 32'(bus.tie), 32'd0);
      repeat (NM * P) tick();
      chk("abort_no_done", 32'(done_cnt), 32'(dc));
      bus.ena = 1'b1;
      tick();
    end else begin
      if (poke) begin
        n = 0;
        while (bus.cnt_en !== 1'b1 && n < 100) begin tick(); n++; end
        while (bus.cnt_en === 1'b1 && n < 100) begin tick(); n++; end
        tick();
        bus.seed  = ~sd;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
      end
      n = 0;
      while (exp_res_q.size() != 0 && n < NM * P + 40) begin tick(); n++; end
      checks++;
      if (exp_res_q.size() != 0) begin
        errors++;
        $display("FAIL done_timeout: got no done expected one within %0d cycles", NM * P + 40);
        exp_res_q.delete();
        exp_chal_q.delete();
      end
      repeat (3) tick();
      chk("response_hold", 32'(bus.response), 32'(last_res.resp));
      chk("tie_hold", 32'(bus.tie), 32'(last_res.tie));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.ena   = 1'b1;
    bus.seed  = 4'h9;
    repeat (3) begin
      tick();
      chk("reset_outputs",
          32'({bus.challenge, bus.cnt_clr, bus.cnt_en, bus.busy, bus.done, bus.tie, bus.response}),
          32'd0);
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    mon_on    = 1'b1;
    repeat (2) tick();

    // seed 2: A>B on 2 and 4, A<B on 3 and 5
    fill_bit(0, 1); fill_bit(1, 0); fill_bit(2, 1); fill_bit(3, 0);
    do_run(4'h2, 1'b0, 1'b0);

    // seed E wraps E,F,0,1 with equal counts on challenge 0
    fill_random(1'b0);
    fill_bit(2, 2);
    do_run(4'hE, 1'b0, 1'b0);

    fill_random(1'b0);
    set_rel(0, 2);
    do_run(4'($urandom), 1'b1, 1'b0);

    fill_random(1'b0);
    do_run(4'h7, 1'b0, 1'b1);

    fill_random(1'b0);
`ifdef PUF_MAJORITY_EN
    set_rel(0, 1); set_rel(1, 0); set_rel(2, 1);
`endif
    do_run(4'hA, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      fill_random(1'b1);
      do_run(4'($urandom), 1'b0, 1'b0);
    end

    chk("pending_challenges", 32'(exp_chal_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/puf_challenge_ctrl.md
# puf_challenge_ctrl

Challenge-side controller for the ring-oscillator PUF: it issues a sequence of 4-bit challenges to the two oscillator/counter banks, gates the counting window, samples both 16-bit counts once they settle, and turns each comparison into one response bit. The result is an N-bit response word with a completion pulse. The block sits between the system/host interface and the oscillator banks. The banks answer challenges; this block initiates them and collects the answers.

## Interface
Parameters:
- WINDOW_CYCLES, 1024: clk cycles per counting window (≥1).
- SETTLE_CYCLES, 4: clk cycles between window close and count sampling (≥1); lets the ripple counters settle.
- N_BITS, 8: response bits per run (1..16).

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- ena  in  1  block enable; low aborts any run.
- start  in  1  single-cycle request to begin a run.
- seed  in  4  first challenge of the run.
- count_a  in  16  bank A count; stable whenever cnt_en=0 for ≥SETTLE_CYCLES.
- count_b  in  16  bank B count; same stability condition as count_a.
- challenge  out  4  oscillator-select to both banks.
- cnt_clr  out  1  counter clear to both banks, one-cycle pulse.
- cnt_en  out  1  oscillator/count enable to both banks.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when the response is complete.
- response  out  N_BITS  response word; bit i comes from challenge i.
- tie  out  1  sticky flag; set if any comparison in the run had equal counts.

## Operation
- FSM states: IDLE, CLEAR, COUNT, SETTLE, COMPARE, DONE.
- IDLE:
  - start=1 with ena=1 → CLEAR, bit index i=0, challenge=seed, response=0, tie=0.
  - start while not IDLE is ignored.
- CLEAR: cnt_clr=1 for one cycle; challenge is held. Next state is COUNT.
- COUNT: cnt_en=1 for exactly WINDOW_CYCLES cycles. Next state is SETTLE.
- SETTLE: cnt_en=0 for SETTLE_CYCLES cycles. Next state is COMPARE.
- COMPARE: count_a and count_b are sampled this cycle.
  - response[i] = (count_a > count_b), unsigned 16-bit compare.
  - Equal counts give bit 0 and set tie.
  - If i==N_BITS-1 → DONE. Otherwise i+1, challenge = challenge+1 mod 16 (4'hF wraps to 4'h0), → CLEAR.
- DONE: done=1 for one cycle, then → IDLE.
- response and tie hold until the next accepted start.
- busy=1 in every state except IDLE.
- ena=0 in any non-IDLE state, at the next edge:
  - → IDLE; cnt_en=0, cnt_clr=0, response=0, tie=0, no done pulse.
  - challenge keeps its last value.
- Reset values: challenge=0, cnt_clr=0, cnt_en=0, busy=0, done=0, response=0, tie=0, state=IDLE.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- start is sampled at edge 0; CLEAR is visible in the cycle after edge 0.
- Per-bit cost is P = WINDOW_CYCLES + SETTLE_CYCLES + 2 cycles.
- done is high in cycle N_BITS·P + 1 counted from the start edge, and response is valid in the same cycle.
- challenge changes only on the COMPARE→CLEAR transition, so it is stable for the whole CLEAR/COUNT/SETTLE/COMPARE span.
- rst_n low overrides ena and start; its effect is seen at the next clk edge.

## Configuration
- PUF_MAJORITY_EN defined:
  - Each challenge is measured 3 times (CLEAR/COUNT/SETTLE/COMPARE ×3).
  - response[i] is the majority of the three comparison bits.
  - tie is set if any of the three compares was equal.
  - Per-bit cost becomes 3·P; done lands in cycle 3·N_BITS·P + 1.
- Undefined: one measurement per challenge, as described above.

## Test plan
- Use WINDOW_CYCLES=16, SETTLE_CYCLES=4, N_BITS=4, so P=22.
- Reset: hold rst_n=0 for 3 cycles with start=1 → all outputs 0, busy=0, no cnt_en.
- Basic run, seed=4'h2:
  - Model returns count_a>count_b for challenges 2 and 4, less for 3 and 5.
  - Expected: challenges 2,3,4,5 in order; cnt_en high 16 cycles per bit; done in cycle 89; response=4'b0101; tie=0.
- Wrap and tie, seed=4'hE:
  - Expected challenge sequence E,F,0,1.
  - Equal counts on challenge 0 → response[2]=0 and tie=1.
- Abort: ena=0 during the second COUNT → IDLE next edge; cnt_en=0, busy=0, response=0, no done pulse.
- Start while busy: pulse start during SETTLE with a new seed → ignored; sequence and done timing unchanged.
- With PUF_MAJORITY_EN: model gives A>B, A<B, A>B on the three measurements of bit 0 → response[0]=1; done in cycle 265.
